traffic_light_monitor: RTL and testbench
========================================

Name: traffic_light_monitor

Overview:
- Passive checker on the lamp side of the two-road intersection controller interface.
- Samples the six lamp lines (ra, ya, ga, rb, yb, gb) and the two road sensors (sa, sb) every clock.
- Decodes the lamp pattern into a phase, tracks how long each phase has lasted, and checks order, timing and sensor-driven advance rules.
- Latches the first violation as a sticky fault with a code; intended to drive a fail-safe flash-red override and debug registers.

Parameters:
- MIN_AG, 6, minimum consecutive A-green samples before an advance is legal.
- MIN_BG, 5, minimum consecutive B-green samples before an advance is legal.
- Y_LEN, 1, exact number of samples for each yellow phase.
- DW, 8, width of the dwell counter and the cycle counter.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- clr_fault  in  1  synchronous clear of fault and fault_code.
- sa  in  1  road-A sensor.
- sb  in  1  road-B sensor.
- ra, ya, ga  in  1 each  road-A lamps.
- rb, yb, gb  in  1 each  road-B lamps.
- phase  out  2  decoded phase: 0 AG, 1 AY, 2 BG, 3 BY.
- phase_valid  out  1  current lamp pattern is one of the four legal patterns.
- dwell  out  DW  consecutive samples in the current phase, saturating at all-ones.
- fault  out  1  sticky fault flag.
- fault_code  out  3  code of the first fault since reset or clear.
- cycle_count  out  DW  completed AG→AY→BG→BY cycles, wraps modulo 2^DW.

Behaviour:
- Legal lamp patterns (ra ya ga rb yb gb):
  - AG = 001100
  - AY = 010100
  - BG = 100001
  - BY = 100010
  - Any other pattern is illegal, including dark, both green, and multiple lamps lit on one road.
- Reset values:
  - phase = AG, phase_valid = 1, dwell = 0.
  - fault = 0, fault_code = 0, cycle_count = 0.
  - expect_phase = AG; must_adv = 0; must_hold = 0.
- All outputs are registered. They reflect the sample taken at the most recent edge.
- Legal-pattern sample:
  - Same phase as the previous sample: dwell increments, saturating.
  - Different phase: dwell = 1.
  - First sample after reset: dwell = 1 if the phase is AG.
- Illegal-pattern sample: phase_valid = 0, phase holds its last value, dwell resets to 0, expect_phase is unchanged.
- Advance rules are evaluated on the sample at edge k and checked against the sample at edge k+1:
  - AG with dwell ≥ MIN_AG: if sb = 1, must_adv is set (next sample must be AY); otherwise must_hold is set (next sample must be AG).
  - BG with dwell ≥ MIN_BG: if (~sa & sb), must_hold is set; otherwise must_adv is set (next sample must be BY).
  - AY or BY with dwell = Y_LEN: must_adv is set.
- Fault codes, in priority order (lowest number wins on the same edge):
  - 1 ILLEGAL_LAMPS: illegal pattern.
  - 2 BAD_ORDER: phase changed to something other than its successor (AG→AY→BG→BY→AG).
  - 3 EARLY_EXIT: phase left with dwell < minimum, or left while must_hold.
  - 4 YELLOW_OVERSTAY: AY/BY dwell exceeds Y_LEN.
  - 5 MISSED_ADVANCE: must_adv set but the phase did not change.
- Fault latching:
  - On the first fault, fault = 1 and fault_code = code. Later faults do not overwrite the code.
  - clr_fault clears fault and fault_code on the next edge; checking continues.
  - If clr_fault and a new fault occur on the same edge, the new fault is latched.
- cycle_count increments on a legal BY→AG transition only.
- After any fault, phase tracking resynchronises to the sampled phase. Subsequent checks are relative to it.
- Reset mid-operation clears everything immediately (asynchronous). The first post-reset sample is expected to be AG with dwell 1.

Decomposition:
- Shared package traffic_pkg:
  - phase encodings AG/AY/BG/BY.
  - fault code constants.
  - the legal lamp patterns as 6-bit constants.
- Sub-module lamp_phase_decoder (combinational): lamp vector → phase plus valid.
- The monitor holds the dwell counter, rule registers and fault latch.

Test Plan:
- Normal cycle, sa = 1, sb = 1: AG×6, AY×1, BG×5, BY×1, repeated 3 times → fault = 0, cycle_count = 3, dwell peaks at 6 and 5.
- sb = 0 for 20 samples with AG held, then sb = 1 → no fault; AY appears the sample after sb is seen high at dwell ≥ 6.
- Lamps 001001 (both green) injected at AG dwell 3 → next edge fault = 1, fault_code = 1, phase_valid = 0.
- AG→AY after only 3 AG samples → fault_code = 3. Then AY held 2 samples → fault_code stays 3. Then clr_fault → fault = 0.
- BG dwell 5 with sa = 1, but lamps stay BG → fault_code = 5. In a separate run, AG→BG directly → fault_code = 2.
- Reset asserted mid-BG, then released → all outputs at reset values. Next AG sample gives dwell = 1 and no fault.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection lamp monitor: phase and fault
// encodings, the four legal lamp patterns, and small phase helpers.
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_AG = 2'd0,
        PH_AY = 2'd1,
        PH_BG = 2'd2,
        PH_BY = 2'd3
    } phase_e;

    typedef enum logic [2:0] {
        FC_NONE            = 3'd0,
        FC_ILLEGAL_LAMPS   = 3'd1,
        FC_BAD_ORDER       = 3'd2,
        FC_EARLY_EXIT      = 3'd3,
        FC_YELLOW_OVERSTAY = 3'd4,
        FC_MISSED_ADVANCE  = 3'd5
    } fault_code_e;

    // Lamp vectors ordered {ra, ya, ga, rb, yb, gb}
    localparam logic [5:0] LAMPS_AG = 6'b001100;
    localparam logic [5:0] LAMPS_AY = 6'b010100;
    localparam logic [5:0] LAMPS_BG = 6'b100001;
    localparam logic [5:0] LAMPS_BY = 6'b100010;

    // Legal successor in the fixed AG -> AY -> BG -> BY -> AG rotation
    function automatic phase_e next_phase(input phase_e p);
        phase_e n;
        case (p)
            PH_AG:   n = PH_AY;
            PH_AY:   n = PH_BG;
            PH_BG:   n = PH_BY;
            default: n = PH_AG;
        endcase
        return n;
    endfunction

    function automatic logic is_yellow(input phase_e p);
        return (p == PH_AY) || (p == PH_BY);
    endfunction

endpackage

// File: rtl/lamp_phase_decoder.sv
// Combinational decode of the six lamp lines into a phase plus a legality
// flag. Anything that is not exactly one of the four legal patterns
// (dark, both green, several lamps on one road, ...) is reported invalid.
module lamp_phase_decoder
    import traffic_pkg::*;
(
    input  logic [5:0] lamps_i,
    output phase_e     phase_o,
    output logic       valid_o
);

    // Exact-match decode against the legal pattern table
    always_comb begin
        phase_o = PH_AG;
        valid_o = 1'b1;
        case (lamps_i)
            LAMPS_AG: phase_o = PH_AG;
            LAMPS_AY: phase_o = PH_AY;
            LAMPS_BG: phase_o = PH_BG;
            LAMPS_BY: phase_o = PH_BY;
            default:  valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive lamp-side checker for the two-road intersection controller.
// Each edge samples lamps and sensors, tracks the phase and its dwell,
// checks order/timing/advance rules and latches the first fault (sticky).
// The tracked phase register doubles as the expected-phase reference, so
// after any fault the checks resynchronise to whatever phase was sampled.
// Rules derived from the sample at edge k (must_adv/must_hold) are
// checked against the sample at edge k+1. After an illegal sample the
// next legal sample is accepted without order or exit checks.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_AG = 6,
    parameter int MIN_BG = 5,
    parameter int Y_LEN  = 1,
    parameter int DW     = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_fault,
    input  logic          sa,
    input  logic          sb,
    input  logic          ra,
    input  logic          ya,
    input  logic          ga,
    input  logic          rb,
    input  logic          yb,
    input  logic          gb,
    output logic [1:0]    phase,
    output logic          phase_valid,
    output logic [DW-1:0] dwell,
    output logic          fault,
    output logic [2:0]    fault_code,
    output logic [DW-1:0] cycle_count
);

    localparam logic [DW-1:0] MIN_AG_W = DW'(MIN_AG);
    localparam logic [DW-1:0] MIN_BG_W = DW'(MIN_BG);
    localparam logic [DW-1:0] Y_LEN_W  = DW'(Y_LEN);
    localparam logic [DW-1:0] DW_ONE   = DW'(1);
    localparam logic [DW-1:0] DW_MAX   = {DW{1'b1}};

    phase_e          lamp_phase;
    logic            lamp_valid;

    phase_e          phase_q, phase_d;
    logic            valid_q, valid_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic            must_adv_q, must_adv_d;
    logic            must_hold_q, must_hold_d;
    logic            fault_q, fault_d;
    logic [2:0]      fault_code_q, fault_code_d;
    logic [DW-1:0]   cycle_q, cycle_d;

    fault_code_e     code_now;
    logic            same_phase;
    logic            phase_changed;
    logic [DW-1:0]   min_dwell;

    lamp_phase_decoder u_decoder (
        .lamps_i ({ra, ya, ga, rb, yb, gb}),
        .phase_o (lamp_phase),
        .valid_o (lamp_valid)
    );

    // Phase tracker state register (async reset to AG, valid)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= PH_AG;
            valid_q <= 1'b1;
        end else begin
            phase_q <= phase_d;
            valid_q <= valid_d;
        end
    end

    // Next phase: follow legal samples, hold the last phase on illegal ones
    always_comb begin
        phase_d = phase_q;
        valid_d = lamp_valid;
        if (lamp_valid) begin
            phase_d = lamp_phase;
        end
    end

    // Registered outputs straight from the state and datapath registers
    always_comb begin
        phase       = phase_q;
        phase_valid = valid_q;
        dwell       = dwell_q;
        fault       = fault_q;
        fault_code  = fault_code_q;
        cycle_count = cycle_q;
    end

    // Minimum dwell required before the tracked phase may be left
    always_comb begin
        case (phase_q)
            PH_AG:   min_dwell = MIN_AG_W;
            PH_BG:   min_dwell = MIN_BG_W;
            default: min_dwell = Y_LEN_W;
        endcase
    end

    // Fault detection for this sample; lowest code wins
    always_comb begin
        same_phase    = valid_q && lamp_valid && (lamp_phase == phase_q);
        phase_changed = valid_q && lamp_valid && (lamp_phase != phase_q);
        code_now      = FC_NONE;
        if (!lamp_valid) begin
            code_now = FC_ILLEGAL_LAMPS;
        end else if (phase_changed) begin
            if (lamp_phase != next_phase(phase_q)) begin
                code_now = FC_BAD_ORDER;
            end else if ((dwell_q < min_dwell) || must_hold_q) begin
                code_now = FC_EARLY_EXIT;
            end
        end else if (same_phase) begin
            if (is_yellow(phase_q) && (dwell_q >= Y_LEN_W)) begin
                code_now = FC_YELLOW_OVERSTAY;
            end else if (must_adv_q) begin
                code_now = FC_MISSED_ADVANCE;
            end
        end
    end

    // Dwell counting and the advance/hold obligations for the next sample
    always_comb begin
        dwell_d     = '0;
        must_adv_d  = 1'b0;
        must_hold_d = 1'b0;
        if (lamp_valid) begin
            if (same_phase) begin
                dwell_d = (dwell_q == DW_MAX) ? dwell_q : dwell_q + DW_ONE;
            end else begin
                dwell_d = DW_ONE;
            end
            case (lamp_phase)
                PH_AG: begin
                    if (dwell_d >= MIN_AG_W) begin
                        must_adv_d  = sb;
                        must_hold_d = !sb;
                    end
                end
                PH_BG: begin
                    if (dwell_d >= MIN_BG_W) begin
                        must_hold_d = !sa && sb;
                        must_adv_d  = !(!sa && sb);
                    end
                end
                default: begin
                    if (dwell_d == Y_LEN_W) begin
                        must_adv_d = 1'b1;
                    end
                end
            endcase
        end
    end

    // Sticky fault latch and completed-cycle counter
    always_comb begin
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        cycle_d      = cycle_q;
        if (!fault_q || clr_fault) begin
            fault_d      = (code_now != FC_NONE);
            fault_code_d = code_now;
        end
        if (phase_changed && (phase_q == PH_BY) && (lamp_phase == PH_AG) &&
            (code_now == FC_NONE)) begin
            cycle_d = cycle_q + DW_ONE;
        end
    end

    // Datapath registers: dwell, rule flags, fault latch, cycle counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell_q      <= '0;
            must_adv_q   <= 1'b0;
            must_hold_q  <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= 3'd0;
            cycle_q      <= '0;
        end else begin
            dwell_q      <= dwell_d;
            must_adv_q   <= must_adv_d;
            must_hold_q  <= must_hold_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            cycle_q      <= cycle_d;
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios checked against
// values stated for each scenario, plus a randomized run checked against a
// behavioural model of the lamp rules kept in this file.
module tb_traffic_light_monitor;

    logic       clk = 1'b0;
    logic       reset, clr_fault, sa, sb;
    logic       ra, ya, ga, rb, yb, gb;
    logic [1:0] phase;
    logic       phase_valid, fault;
    logic [7:0] dwell, cycle_count;
    logic [2:0] fault_code;

    int total = 0;
    int bad   = 0;

    // Lamp patterns {ra,ya,ga,rb,yb,gb} indexed by phase 0 AG,1 AY,2 BG,3 BY
    logic [5:0] lamp_tab [4] = '{6'b001100, 6'b010100, 6'b100001, 6'b100010};
    int         min_tab  [4] = '{6, 1, 5, 1};
    localparam int Y_LEN = 1;

    // Reference model state
    int m_phase, m_dwell, m_code, m_cycles, m_need; // need: 0 none, 1 advance, 2 hold
    bit m_valid, m_fault;

    traffic_light_monitor dut (
        .clk(clk), .reset(reset), .clr_fault(clr_fault), .sa(sa), .sb(sb),
        .ra(ra), .ya(ya), .ga(ga), .rb(rb), .yb(yb), .gb(gb),
        .phase(phase), .phase_valid(phase_valid), .dwell(dwell),
        .fault(fault), .fault_code(fault_code), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase = 0; m_valid = 1; m_dwell = 0; m_need = 0;
        m_fault = 0; m_code = 0; m_cycles = 0;
    endtask

    // Apply one sample of the intersection rules to the model
    task automatic model_update(input logic [5:0] l, input bit s_a, input bit s_b, input bit clr);
        int cur = -1;
        int code = 0;
        for (int i = 0; i < 4; i++) if (lamp_tab[i] == l) cur = i;
        if (cur < 0) begin
            code = 1;
            m_valid = 0; m_dwell = 0; m_need = 0;
        end else begin
            if (m_valid && cur != m_phase) begin
                if (cur != (m_phase + 1) % 4) code = 2;
                else if (m_dwell < min_tab[m_phase] || m_need == 2) code = 3;
                if (code == 0 && m_phase == 3 && cur == 0) m_cycles = (m_cycles + 1) % 256;
                m_dwell = 1;
            end else if (m_valid) begin
                if ((cur == 1 || cur == 3) && m_dwell + 1 > Y_LEN) code = 4;
                else if (m_need == 1) code = 5;
                m_dwell = (m_dwell == 255) ? 255 : m_dwell + 1;
            end else begin
                m_dwell = 1;
            end
            m_phase = cur; m_valid = 1; m_need = 0;
            if (cur == 0 && m_dwell >= 6) m_need = s_b ? 1 : 2;
            if (cur == 2 && m_dwell >= 5) m_need = (!s_a && s_b) ? 2 : 1;
            if ((cur == 1 || cur == 3) && m_dwell == Y_LEN) m_need = 1;
        end
        if (!m_fault || clr) begin
            m_fault = (code != 0);
            m_code  = code;
        end
    endtask

    // Drive one sample, let the DUT take it, update the model, settle
    task automatic step(input logic [5:0] l, input bit s_a, input bit s_b, input bit clr);
        {ra, ya, ga, rb, yb, gb} = l;
        sa = s_a; sb = s_b; clr_fault = clr;
        @(posedge clk);
        model_update(l, s_a, s_b, clr);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {ra, ya, ga, rb, yb, gb} = lamp_tab[0];
        clr_fault = 1'b0; sa = 1'b0; sb = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        total++; if (phase !== 2'd0) begin bad++; $display("FAIL reset_phase: got %0d exp 0", phase); end
        total++; if (phase_valid !== 1'b1) begin bad++; $display("FAIL reset_valid: got %0d exp 1", phase_valid); end
        total++; if (dwell !== 8'd0) begin bad++; $display("FAIL reset_dwell: got %0d exp 0", dwell); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault: got %0d exp 0", fault); end
        total++; if (fault_code !== 3'd0) begin bad++; $display("FAIL reset_code: got %0d exp 0", fault_code); end
        total++; if (cycle_count !== 8'd0) begin bad++; $display("FAIL reset_cycles: got %0d exp 0", cycle_count); end
        do_reset();
    endtask

    task automatic test_normal_cycle();
        int ag_max = 0;
        int bg_max = 0;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 6; i++) begin step(lamp_tab[0], 1, 1, 0); if (dwell > ag_max) ag_max = dwell; end
            step(lamp_tab[1], 1, 1, 0);
            for (int i = 0; i < 5; i++) begin step(lamp_tab[2], 1, 1, 0); if (dwell > bg_max) bg_max = dwell; end
            step(lamp_tab[3], 1, 1, 0);
        end
        step(lamp_tab[0], 1, 1, 0);
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL normal_fault: got %0d exp 0 (code %0d)", fault, fault_code); end
        total++; if (cycle_count !== 8'd3) begin bad++; $display("FAIL normal_cycles: got %0d exp 3", cycle_count); end
        total++; if (ag_max != 6) begin bad++; $display("FAIL normal_ag_peak: got %0d exp 6", ag_max); end
        total++; if (bg_max != 5) begin bad++; $display("FAIL normal_bg_peak: got %0d exp 5", bg_max); end
        total++; if (dwell !== 8'd1) begin bad++; $display("FAIL normal_new_ag_dwell: got %0d exp 1", dwell); end
    endtask

    task automatic test_hold_sb();
        do_reset();
        for (int i = 0; i < 20; i++) step(lamp_tab[0], 0, 0, 0);
        total++; if (fault !== 1'b0 || dwell !== 8'd20) begin bad++; $display("FAIL hold_wait: got fault %0d dwell %0d exp 0 20", fault, dwell); end
        step(lamp_tab[0], 0, 1, 0);
        step(lamp_tab[1], 0, 1, 0);
        total++; if (fault !== 1'b0 || phase !== 2'd1) begin bad++; $display("FAIL hold_advance: got fault %0d phase %0d exp 0 1", fault, phase); end
        // leaving AG while the sensor demands a hold is an early exit
        do_reset();
        for (int i = 0; i < 6; i++) step(lamp_tab[0], 0, 0, 0);
        step(lamp_tab[1], 0, 0, 0);
        total++; if (fault_code !== 3'd3) begin bad++; $display("FAIL hold_violate: got %0d exp 3", fault_code); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 260; i++) step(lamp_tab[0], 0, 0, 0);
        total++; if (dwell !== 8'd255 || fault !== 1'b0) begin bad++; $display("FAIL dwell_saturate: got dwell %0d fault %0d exp 255 0", dwell, fault); end
    endtask

    task automatic test_both_green();
        do_reset();
        for (int i = 0; i < 3; i++) step(lamp_tab[0], 1, 1, 0);
        step(6'b001001, 1, 1, 0);
        total++; if (fault !== 1'b1 || fault_code !== 3'd1) begin bad++; $display("FAIL both_green_code: got %0d/%0d exp 1/1", fault, fault_code); end
        total++; if (phase_valid !== 1'b0 || phase !== 2'd0 || dwell !== 8'd0) begin bad++; $display("FAIL both_green_track: got v%0d p%0d d%0d exp v0 p0 d0", phase_valid, phase, dwell); end
    endtask

    task automatic test_early_exit_clear();
        do_reset();
        for (int i = 0; i < 3; i++) step(lamp_tab[0], 1, 1, 0);
        step(lamp_tab[1], 1, 1, 0);
        total++; if (fault_code !== 3'd3) begin bad++; $display("FAIL early_exit: got %0d exp 3", fault_code); end
        step(lamp_tab[1], 1, 1, 0);
        total++; if (fault_code !== 3'd3 || fault !== 1'b1) begin bad++; $display("FAIL early_sticky: got %0d exp 3", fault_code); end
        step(lamp_tab[2], 1, 1, 1);
        total++; if (fault !== 1'b0 || fault_code !== 3'd0) begin bad++; $display("FAIL early_clear: got %0d/%0d exp 0/0", fault, fault_code); end
    endtask

    task automatic test_missed_and_order();
        do_reset();
        for (int i = 0; i < 6; i++) step(lamp_tab[0], 1, 1, 0);
        step(lamp_tab[1], 1, 1, 0);
        for (int i = 0; i < 5; i++) step(lamp_tab[2], 1, 0, 0);
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL missed_pre: got %0d exp 0", fault); end
        step(lamp_tab[2], 1, 0, 0);
        total++; if (fault_code !== 3'd5) begin bad++; $display("FAIL missed_advance: got %0d exp 5", fault_code); end
        do_reset();
        for (int i = 0; i < 2; i++) step(lamp_tab[0], 1, 1, 0);
        step(lamp_tab[2], 1, 1, 0);
        total++; if (fault_code !== 3'd2) begin bad++; $display("FAIL bad_order: got %0d exp 2", fault_code); end
        total++; if (phase !== 2'd2 || dwell !== 8'd1) begin bad++; $display("FAIL bad_order_resync: got p%0d d%0d exp p2 d1", phase, dwell); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) step(lamp_tab[0], 1, 1, 0);
        step(lamp_tab[1], 1, 1, 0);
        step(lamp_tab[2], 1, 1, 0);
        step(lamp_tab[2], 1, 1, 0);
        #2 reset = 1'b1;
        #1;
        total++; if (phase !== 2'd0 || phase_valid !== 1'b1 || dwell !== 8'd0) begin bad++; $display("FAIL midreset_phase: got p%0d v%0d d%0d exp 0 1 0", phase, phase_valid, dwell); end
        total++; if (fault !== 1'b0 || fault_code !== 3'd0 || cycle_count !== 8'd0) begin bad++; $display("FAIL midreset_fault: got %0d/%0d/%0d exp 0", fault, fault_code, cycle_count); end
        do_reset();
        step(lamp_tab[0], 1, 1, 0);
        total++; if (dwell !== 8'd1 || fault !== 1'b0 || phase !== 2'd0) begin bad++; $display("FAIL midreset_first: got d%0d f%0d p%0d exp 1 0 0", dwell, fault, phase); end
    endtask

    task automatic test_random();
        logic [5:0] l;
        int ph;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                l = 6'($urandom);
            end else begin
                ph = m_phase;
                if (m_need == 1) begin
                    if ($urandom_range(0, 19) != 0) ph = (ph + 1) % 4;
                end else if (m_need == 2) begin
                    if ($urandom_range(0, 19) == 0) ph = (ph + 1) % 4;
                end else if ($urandom_range(0, 7) == 0) begin
                    ph = (ph + 1) % 4;
                end
                if ($urandom_range(0, 49) == 0) ph = $urandom_range(0, 3);
                l = lamp_tab[ph];
            end
            step(l, 1'($urandom), 1'($urandom), $urandom_range(0, 15) == 0);
            total++; if (phase !== 2'(m_phase)) begin bad++; $display("FAIL rnd_phase n=%0d: got %0d exp %0d", n, phase, m_phase); end
            total++; if (phase_valid !== m_valid) begin bad++; $display("FAIL rnd_valid n=%0d: got %0d exp %0d", n, phase_valid, m_valid); end
            total++; if (dwell !== 8'(m_dwell)) begin bad++; $display("FAIL rnd_dwell n=%0d: got %0d exp %0d", n, dwell, m_dwell); end
            total++; if (fault !== m_fault) begin bad++; $display("FAIL rnd_fault n=%0d: got %0d exp %0d", n, fault, m_fault); end
            total++; if (fault_code !== 3'(m_code)) begin bad++; $display("FAIL rnd_code n=%0d: got %0d exp %0d", n, fault_code, m_code); end
            total++; if (cycle_count !== 8'(m_cycles)) begin bad++; $display("FAIL rnd_cycles n=%0d: got %0d exp %0d", n, cycle_count, m_cycles); end
        end
    endtask

    initial begin
        reset = 1'b1; clr_fault = 1'b0; sa = 1'b0; sb = 1'b0;
        {ra, ya, ga, rb, yb, gb} = 6'b001100;
        model_reset();
        test_reset();
        test_normal_cycle();
        test_hold_sb();
        test_saturation();
        test_both_green();
        test_early_exit_clear();
        test_missed_and_order();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
